// File: rtl/output_drain_scheduler_pkg.sv
// Shared types for the output drain scheduler: FSM states and the buffered packet layout.
// DATA_WIDTH/NB_PAR on the top module must match the package widths below.
package output_drain_scheduler_pkg;

  localparam int ODS_DATA_WIDTH = 32;
  localparam int ODS_NB_PAR     = 3;
  localparam int ODS_COORD_W    = 32;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } drain_state_t;

  typedef struct packed {
    logic [ODS_COORD_W-1:0]               x;
    logic [ODS_COORD_W-1:0]               y;
    logic [ODS_COORD_W-1:0]               ch;
    logic [ODS_NB_PAR*ODS_DATA_WIDTH-1:0] data;
  } packet_t;

  localparam int PACKET_W = $bits(packet_t);

endpackage

// File: rtl/output_drain_scheduler_fifo.sv
// Synchronous packet FIFO with flush; head entry is visible combinationally on rdata_o.
// A pop at full frees the slot so a simultaneous push is accepted.
module packet_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             arst_n_in,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_q];

  assign pop_ok  = pop_i && !empty_o && !clear_i;
  assign push_ok = push_i && (!full_o || pop_ok) && !clear_i;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q + CW'(push_ok) - CW'(pop_ok);
    if (push_ok) wr_d = wr_q + 1'b1;
    if (pop_ok)  rd_d = rd_q + 1'b1;
    if (clear_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage carries no reset; occupancy is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/output_drain_scheduler.sv
// Buffers NB_PAR-wide result packets and serializes them one channel value per host handshake.
// Raises stall one slot before full so a single in-flight packet is never lost.
module output_drain_scheduler
  import output_drain_scheduler_pkg::*;
#(
  parameter int DATA_WIDTH = ODS_DATA_WIDTH,
  parameter int NB_PAR     = ODS_NB_PAR,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         arst_n_in,
  input  logic                         clear,
  input  logic                         in_valid,
  input  logic [31:0]                  in_x,
  input  logic [31:0]                  in_y,
  input  logic [31:0]                  in_ch,
  input  logic [NB_PAR*DATA_WIDTH-1:0] in_data,
  output logic                         stall,
  output logic                         host_valid,
  input  logic                         host_ready,
  output logic [DATA_WIDTH-1:0]        host_data,
  output logic [31:0]                  host_x,
  output logic [31:0]                  host_y,
  output logic [31:0]                  host_ch,
  output logic                         overflow,
  output logic                         busy
);

  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int IDX_W = (NB_PAR > 1) ? $clog2(NB_PAR) : 1;

  drain_state_t     state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  packet_t          pkt_q, pkt_d;
  logic             overflow_q, overflow_d;

  packet_t          in_pkt, head_pkt;
  logic             fifo_full, fifo_empty, pop;
  logic [CW-1:0]    fifo_count;
  logic             hs, last;

  assign in_pkt.x    = in_x;
  assign in_pkt.y    = in_y;
  assign in_pkt.ch   = in_ch;
  assign in_pkt.data = in_data;

  packet_fifo #(
    .WIDTH (PACKET_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .arst_n_in (arst_n_in),
    .clear_i   (clear),
    .push_i    (in_valid),
    .pop_i     (pop),
    .wdata_i   (in_pkt),
    .rdata_o   (head_pkt),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  assign host_valid = (state_q == EMIT);
  assign hs         = host_valid && host_ready;
  assign last       = (idx_q == IDX_W'(NB_PAR - 1));

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pkt_d      = pkt_q;
    pop        = 1'b0;
    overflow_d = overflow_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          pkt_d   = head_pkt;
          idx_d   = '0;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (hs) begin
          if (!last) begin
            idx_d = idx_q + 1'b1;
          end else if (!fifo_empty) begin
            // Next packet loaded on the same edge as the last transfer: no bubble.
            pop   = 1'b1;
            pkt_d = head_pkt;
            idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (in_valid && fifo_full && !pop) overflow_d = 1'b1;
    if (clear) begin
      state_d    = IDLE;
      idx_d      = '0;
      pop        = 1'b0;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      pkt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pkt_q      <= pkt_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    host_data = '0;
    for (int k = 0; k < NB_PAR; k++) begin
      if (idx_q == IDX_W'(k)) host_data = pkt_q.data[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign host_x   = pkt_q.x;
  assign host_y   = pkt_q.y;
  assign host_ch  = pkt_q.ch + 32'(idx_q);
  assign overflow = overflow_q;
  assign stall    = (fifo_count >= CW'(FIFO_DEPTH - 1));
  assign busy     = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_output_drain_scheduler.sv
// Directed bench for output_drain_scheduler: latency, backpressure, overflow, clear, streaming, async reset.
module tb_output_drain_scheduler;

  logic        clk = 1'b0;
  logic        arst_n_in;
  logic        clear;
  logic        in_valid;
  logic [31:0] in_x, in_y, in_ch;
  logic [95:0] in_data;
  logic        stall, host_valid, host_ready, overflow, busy;
  logic [31:0] host_data, host_x, host_y, host_ch;

  int tests = 0;
  int fails = 0;

  output_drain_scheduler #(.DATA_WIDTH(32), .NB_PAR(3), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .arst_n_in  (arst_n_in),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_x       (in_x),
    .in_y       (in_y),
    .in_ch      (in_ch),
    .in_data    (in_data),
    .stall      (stall),
    .host_valid (host_valid),
    .host_ready (host_ready),
    .host_data  (host_data),
    .host_x     (host_x),
    .host_y     (host_y),
    .host_ch    (host_ch),
    .overflow   (overflow),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pkt(input logic [31:0] x, y, ch, d0, d1, d2);
    in_valid = 1'b1;
    in_x     = x;
    in_y     = y;
    in_ch    = ch;
    in_data  = {d2, d1, d0};
  endtask

  task automatic test_reset();
    arst_n_in = 1'b0; clear = 1'b0; in_valid = 1'b0; host_ready = 1'b0;
    in_x = '0; in_y = '0; in_ch = '0; in_data = '0;
    #2;
    tests++;
    if ({host_valid, stall, overflow, busy} !== 4'b0000 || host_data !== 32'd0 || host_ch !== 32'd0) begin
      fails++;
      $display("FAIL reset_state: valid/stall/ovf/busy=%b%b%b%b data=%0d ch=%0d required all 0",
               host_valid, stall, overflow, busy, host_data, host_ch);
    end
    step(); step();
    arst_n_in = 1'b1;
    step();
  endtask

  task automatic test_single();
    logic [31:0] exp_d [3] = '{32'd10, 32'd20, 32'd30};
    host_ready = 1'b1;
    drive_pkt(2, 5, 6, 10, 20, 30);
    step();
    in_valid = 1'b0;
    tests++;
    if (host_valid !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL single_cycle1: valid=%b busy=%b required valid=0 busy=1", host_valid, busy);
    end
    step();
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (host_valid !== 1'b1 || host_data !== exp_d[k] || host_ch !== 32'(6 + k) ||
          host_x !== 32'd2 || host_y !== 32'd5) begin
        fails++;
        $display("FAIL single_xfer%0d: valid=%b data=%0d ch=%0d x=%0d y=%0d required 1/%0d/%0d/2/5",
                 k, host_valid, host_data, host_ch, host_x, host_y, exp_d[k], 6 + k);
      end
      step();
    end
    tests++;
    if (host_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL single_idle: valid=%b busy=%b required 0/0", host_valid, busy);
    end
  endtask

  task automatic test_backpressure();
    host_ready = 1'b1;
    drive_pkt(1, 1, 6, 10, 20, 30);
    step();
    in_valid = 1'b0;
    step();
    step();
    host_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tests++;
      if (host_valid !== 1'b1 || host_data !== 32'd20 || host_ch !== 32'd7) begin
        fails++;
        $display("FAIL bp_hold%0d: valid=%b data=%0d ch=%0d required 1/20/7", c, host_valid, host_data, host_ch);
      end
      step();
    end
    host_ready = 1'b1;
    step();
    tests++;
    if (host_valid !== 1'b1 || host_data !== 32'd30 || host_ch !== 32'd8) begin
      fails++;
      $display("FAIL bp_resume: valid=%b data=%0d ch=%0d required 1/30/8", host_valid, host_data, host_ch);
    end
    step();
    tests++;
    if (host_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL bp_idle: valid=%b busy=%b required 0/0", host_valid, busy);
    end
  endtask

  task automatic test_burst_overflow();
    int n = 0;
    host_ready = 1'b0;
    // First packet moves to the output register, so the FIFO fills on the 5th push and the 6th drops.
    for (int i = 0; i < 6; i++) begin
      drive_pkt(i + 1, i + 20, 10 * i, 100 * (i + 1), 100 * (i + 1) + 1, 100 * (i + 1) + 2);
      step();
      tests++;
      if (stall !== (i >= 3) || overflow !== (i >= 5)) begin
        fails++;
        $display("FAIL burst_push%0d: stall=%b ovf=%b required %b/%b", i, stall, overflow, i >= 3, i >= 5);
      end
    end
    in_valid   = 1'b0;
    host_ready = 1'b1;
    for (int c = 0; c < 40 && n < 16; c++) begin
      if (host_valid) begin
        tests++;
        if (host_data !== 32'(100 * (n / 3 + 1) + n % 3) || host_ch !== 32'(10 * (n / 3) + n % 3) ||
            host_x !== 32'(n / 3 + 1)) begin
          fails++;
          $display("FAIL burst_val%0d: data=%0d ch=%0d x=%0d required %0d/%0d/%0d", n, host_data, host_ch,
                   host_x, 100 * (n / 3 + 1) + n % 3, 10 * (n / 3) + n % 3, n / 3 + 1);
        end
        n++;
      end
      step();
    end
    tests++;
    if (n != 15 || busy !== 1'b0 || overflow !== 1'b1) begin
      fails++;
      $display("FAIL burst_total: values=%0d busy=%b ovf=%b required 15/0/1", n, busy, overflow);
    end
  endtask

  task automatic test_clear();
    host_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_pkt(9, 9, 50 * i, 1, 2, 3);
      step();
    end
    in_valid = 1'b0;
    step();
    tests++;
    if (host_valid !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL clear_pre: valid=%b busy=%b required 1/1", host_valid, busy);
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    tests++;
    if (host_valid !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0 || stall !== 1'b0) begin
      fails++;
      $display("FAIL clear_post: valid=%b busy=%b ovf=%b stall=%b required 0/0/0/0", host_valid, busy, overflow, stall);
    end
    host_ready = 1'b1;
    drive_pkt(7, 8, 32'hFFFF_FFFF, 1, 2, 3);
    step();
    in_valid = 1'b0;
    step();
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (host_valid !== 1'b1 || host_data !== 32'(k + 1) || host_ch !== 32'hFFFF_FFFF + 32'(k) ||
          host_x !== 32'd7) begin
        fails++;
        $display("FAIL clear_new%0d: valid=%b data=%0d ch=%h x=%0d required 1/%0d/%h/7", k, host_valid,
                 host_data, host_ch, host_x, k + 1, 32'hFFFF_FFFF + 32'(k));
      end
      step();
    end
    tests++;
    if (host_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL clear_idle: valid=%b busy=%b required 0/0", host_valid, busy);
    end
  endtask

  task automatic test_continuous();
    int n = 0;
    int gaps = 0;
    int stalls = 0;
    bit started = 0;
    host_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (host_valid) begin
        tests++;
        if (host_data !== 32'(1000 * (n / 3 + 1) + n % 3) || host_ch !== 32'(20 + 3 * (n / 3) + n % 3)) begin
          fails++;
          $display("FAIL cont_val%0d: data=%0d ch=%0d required %0d/%0d", n, host_data, host_ch,
                   1000 * (n / 3 + 1) + n % 3, 20 + 3 * (n / 3) + n % 3);
        end
        n++;
        started = 1;
      end else if (started && n < 12) begin
        gaps++;
      end
      if (stall) stalls++;
      if (c % 3 == 0 && c < 12) begin
        drive_pkt(c, c, 20 + c, 1000 * (c / 3 + 1), 1000 * (c / 3 + 1) + 1, 1000 * (c / 3 + 1) + 2);
      end else begin
        in_valid = 1'b0;
      end
      step();
    end
    tests++;
    if (n != 12 || gaps != 0 || stalls != 0 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL cont_summary: values=%0d gaps=%0d stalls=%0d ovf=%b required 12/0/0/0", n, gaps, stalls, overflow);
    end
  endtask

  task automatic test_async_reset();
    host_ready = 1'b1;
    drive_pkt(3, 4, 5, 7, 8, 9);
    step();
    drive_pkt(3, 4, 8, 17, 18, 19);
    step();
    in_valid = 1'b0;
    tests++;
    if (host_valid !== 1'b1 || host_data !== 32'd7) begin
      fails++;
      $display("FAIL arst_pre: valid=%b data=%0d required 1/7", host_valid, host_data);
    end
    #2;
    arst_n_in = 1'b0;
    #1;
    tests++;
    if ({host_valid, stall, overflow, busy} !== 4'b0000 || host_data !== 32'd0 || host_x !== 32'd0 ||
        host_y !== 32'd0 || host_ch !== 32'd0) begin
      fails++;
      $display("FAIL arst_zero: v/s/o/b=%b%b%b%b data=%0d x=%0d y=%0d ch=%0d required all 0",
               host_valid, stall, overflow, busy, host_data, host_x, host_y, host_ch);
    end
    @(posedge clk);
    #1;
    arst_n_in = 1'b1;
    step();
    step();
    tests++;
    if (host_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL arst_empty: valid=%b busy=%b required 0/0", host_valid, busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_burst_overflow();
    test_clear();
    test_continuous();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
